// File: rtl/sram_stage_sequencer_pkg.sv
// Shared types and default timing for the SRAM stage sequencer.
// Defaults assume a 50 MHz system clock.
package sram_seq_pkg;
  localparam int STAGE_IDX_W         = 3;
  localparam int DEF_CNT_W           = 26;
  localparam int DEF_TIMEOUT_CYCLES  = 50_000_000;
  localparam int DEF_WATCHDOG_CYCLES = 2**26 - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_WAIT_VSYNC,
    S_ERROR
  } seq_state_t;
endpackage

// File: rtl/sram_stage_sequencer_if.sv
// Stage, display and SRAM-controller signals of the sequencer.
// The master modport is the sequencer; slave is the surrounding pipeline.
interface sram_stage_sequencer_if #(
  parameter int NUM_STAGES = 3,
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16
);
  logic                         start;
  logic                         abort;
  logic                         vsync_n;
  logic [NUM_STAGES-1:0]        stage_finish;
  logic [NUM_STAGES*ADDR_W-1:0] stage_addr;
  logic [NUM_STAGES*DATA_W-1:0] stage_wdata;
  logic [NUM_STAGES-1:0]        stage_we_n;
  logic [ADDR_W-1:0]            disp_addr;
  logic [NUM_STAGES-1:0]        stage_init;
  logic [NUM_STAGES-1:0]        stage_enable;
  logic                         disp_enable;
  logic [ADDR_W-1:0]            sram_addr;
  logic [DATA_W-1:0]            sram_wdata;
  logic                         sram_we_n;
  logic [2:0]                   cur_stage;
  logic                         busy;
  logic                         done;
  logic                         error;
  logic [2:0]                   error_stage;

  modport master (
    input  start, abort, vsync_n, stage_finish, stage_addr, stage_wdata,
           stage_we_n, disp_addr,
    output stage_init, stage_enable, disp_enable, sram_addr, sram_wdata,
           sram_we_n, cur_stage, busy, done, error, error_stage
  );

  modport slave (
    output start, abort, vsync_n, stage_finish, stage_addr, stage_wdata,
           stage_we_n, disp_addr,
    input  stage_init, stage_enable, disp_enable, sram_addr, sram_wdata,
           sram_we_n, cur_stage, busy, done, error, error_stage
  );
endinterface

// File: rtl/sram_stage_sequencer_mux.sv
// SRAM port mux: the selected stage drives the port while running,
// otherwise the display reader address with writes disabled.
module seq_bus_mux
  import sram_seq_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16
) (
  input  logic                         i_run,
  input  logic [STAGE_IDX_W-1:0]       i_sel,
  input  logic [NUM_STAGES*ADDR_W-1:0] i_stage_addr,
  input  logic [NUM_STAGES*DATA_W-1:0] i_stage_wdata,
  input  logic [NUM_STAGES-1:0]        i_stage_we_n,
  input  logic [ADDR_W-1:0]            i_disp_addr,
  output logic [ADDR_W-1:0]            o_addr,
  output logic [DATA_W-1:0]            o_wdata,
  output logic                         o_we_n
);
  always_comb begin
    o_addr  = i_disp_addr;
    o_wdata = '0;
    o_we_n  = 1'b1;
    if (i_run) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (i_sel == STAGE_IDX_W'(i)) begin
          o_addr  = i_stage_addr[i*ADDR_W +: ADDR_W];
          o_wdata = i_stage_wdata[i*DATA_W +: DATA_W];
          o_we_n  = i_stage_we_n[i];
        end
      end
    end
  end
endmodule

// File: rtl/sram_stage_sequencer.sv
// Sequences exclusive SRAM ownership across NUM_STAGES pipeline stages,
// with inactivity-timeout completion, watchdog error capture and abort.
module sram_stage_sequencer
  import sram_seq_pkg::*;
#(
  parameter int                    NUM_STAGES      = 3,
  parameter int                    ADDR_W          = 18,
  parameter int                    DATA_W          = 16,
  parameter logic [NUM_STAGES-1:0] TIMEOUT_MASK    = NUM_STAGES'(1),
  parameter int                    TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int                    WATCHDOG_CYCLES = DEF_WATCHDOG_CYCLES,
  parameter int                    CNT_W           = DEF_CNT_W
) (
  input logic                    Clock,
  input logic                    Resetn,
  sram_stage_sequencer_if.master bus
);
  seq_state_t             r_state, w_state_nxt;
  logic [STAGE_IDX_W-1:0] r_cur, w_cur_nxt;
  logic [NUM_STAGES-1:0]  r_init, w_init_nxt, r_en, w_en_nxt;
  logic                   r_disp, w_disp_nxt, r_done, w_done_nxt;
  logic                   r_err, w_err_nxt, r_act, w_act_nxt;
  logic [2:0]             r_err_stage, w_err_stage_nxt;
  logic [CNT_W-1:0]       r_tmr, w_tmr_nxt, r_wd, w_wd_nxt;

  // Pad per-stage vectors to 8 bits so the 3-bit stage index always fits.
  logic [7:0] w_we8, w_fin8, w_mask8;
  logic       w_tmo_mode, w_tmo_hit, w_wd_hit, w_stage_done, w_last;

  assign w_we8        = 8'(bus.stage_we_n);
  assign w_fin8       = 8'(bus.stage_finish);
  assign w_mask8      = 8'(TIMEOUT_MASK);
  assign w_tmo_mode   = w_mask8[r_cur];
  assign w_tmo_hit    = (r_tmr == CNT_W'(TIMEOUT_CYCLES - 1)) && r_act;
  assign w_wd_hit     = (WATCHDOG_CYCLES != 0) && (r_wd == CNT_W'(WATCHDOG_CYCLES - 1));
  assign w_stage_done = w_tmo_mode ? w_tmo_hit : w_fin8[r_cur];
  assign w_last       = (r_cur == STAGE_IDX_W'(NUM_STAGES - 1));

  always_comb begin
    w_state_nxt     = r_state;
    w_cur_nxt       = r_cur;
    w_init_nxt      = '0;
    w_en_nxt        = r_en;
    w_disp_nxt      = r_disp;
    w_done_nxt      = 1'b0;
    w_err_nxt       = r_err;
    w_err_stage_nxt = r_err_stage;
    w_tmr_nxt       = r_tmr;
    w_wd_nxt        = r_wd;
    w_act_nxt       = r_act;
    case (r_state)
      S_IDLE: begin
        w_disp_nxt = 1'b1;
        if (bus.start && !bus.abort) begin
          w_cur_nxt   = '0;
          w_disp_nxt  = 1'b0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_init_nxt  = NUM_STAGES'(1) << r_cur;
        w_en_nxt    = NUM_STAGES'(1) << r_cur;
        w_tmr_nxt   = '0;
        w_wd_nxt    = '0;
        w_act_nxt   = 1'b0;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!w_we8[r_cur]) begin
          w_tmr_nxt = '0;
          w_act_nxt = 1'b1;
        end else if (r_tmr != '1) begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
        if (r_wd != '1) w_wd_nxt = r_wd + 1'b1;
        // Completion is checked first so a finish on the expiry cycle wins.
        if (w_stage_done) begin
          w_en_nxt = '0;
          if (w_last) begin
            w_disp_nxt  = 1'b1;
            w_state_nxt = S_WAIT_VSYNC;
          end else begin
            w_cur_nxt   = r_cur + 1'b1;
            w_state_nxt = S_START;
          end
        end else if (!w_tmo_mode && w_wd_hit) begin
          w_err_nxt       = 1'b1;
          w_err_stage_nxt = r_cur;
          w_en_nxt        = '0;
          w_disp_nxt      = 1'b1;
          w_state_nxt     = S_ERROR;
        end
      end
      S_WAIT_VSYNC: begin
        if (!bus.vsync_n) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_ERROR: begin
        if (bus.start) begin
          w_err_nxt   = 1'b0;
          w_cur_nxt   = '0;
          w_disp_nxt  = 1'b0;
          w_state_nxt = S_START;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.abort && r_state != S_IDLE) begin
      w_state_nxt = S_IDLE;
      w_init_nxt  = '0;
      w_en_nxt    = '0;
      w_disp_nxt  = 1'b1;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_state     <= S_IDLE;
      r_cur       <= '0;
      r_init      <= '0;
      r_en        <= '0;
      r_disp      <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_stage <= '0;
      r_tmr       <= '0;
      r_wd        <= '0;
      r_act       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur       <= w_cur_nxt;
      r_init      <= w_init_nxt;
      r_en        <= w_en_nxt;
      r_disp      <= w_disp_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_err_stage <= w_err_stage_nxt;
      r_tmr       <= w_tmr_nxt;
      r_wd        <= w_wd_nxt;
      r_act       <= w_act_nxt;
    end
  end

  seq_bus_mux #(.NUM_STAGES(NUM_STAGES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .i_run         (r_state == S_RUN),
    .i_sel         (r_cur),
    .i_stage_addr  (bus.stage_addr),
    .i_stage_wdata (bus.stage_wdata),
    .i_stage_we_n  (bus.stage_we_n),
    .i_disp_addr   (bus.disp_addr),
    .o_addr        (bus.sram_addr),
    .o_wdata       (bus.sram_wdata),
    .o_we_n        (bus.sram_we_n)
  );

  assign bus.stage_init   = r_init;
  assign bus.stage_enable = r_en;
  assign bus.disp_enable  = r_disp;
  assign bus.cur_stage    = r_cur;
  assign bus.busy         = (r_state != S_IDLE) && (r_state != S_ERROR);
  assign bus.done         = r_done;
  assign bus.error        = r_err;
  assign bus.error_stage  = r_err_stage;
endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Self-checking bench for sram_stage_sequencer: short timeout/watchdog
// parameters, a mux vector table and a stage_init sequence scoreboard.
module tb_sram_stage_sequencer;
  localparam int NS = 3;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam logic [AW-1:0] DISP_A = 18'h2_1234;

  logic Clock = 1'b0;
  logic Resetn;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic [NS-1:0] exp_q[$];
  logic [NS-1:0] mon_exp;

  sram_stage_sequencer_if #(.NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW)) bus();

  sram_stage_sequencer #(
    .NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_MASK(3'b001),
    .TIMEOUT_CYCLES(100), .WATCHDOG_CYCLES(50), .CNT_W(26)
  ) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          we_n;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    logic          exp_we_n;
  } mux_vec_t;
  mux_vec_t tbl[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // Scoreboard: every stage_init pulse must match the next expected stage.
  always @(negedge Clock) begin
    if (Resetn === 1'b1) begin
      if (bus.stage_init != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL init_unexpected got %0h want none", bus.stage_init);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("init_seq", 32'(bus.stage_init), 32'(mon_exp));
        end
      end
      if (bus.done) done_cnt++;
    end
  end

  initial begin
    tbl[0] = '{18'h1ABCD, 16'hBEEF, 1'b0, 18'h1ABCD, 16'hBEEF, 1'b0};
    tbl[1] = '{18'h00000, 16'h0000, 1'b0, 18'h00000, 16'h0000, 1'b0};
    tbl[2] = '{18'h3FFFF, 16'hFFFF, 1'b1, 18'h3FFFF, 16'hFFFF, 1'b1};
    tbl[3] = '{18'h12345, 16'hA5A5, 1'b0, 18'h12345, 16'hA5A5, 1'b0};

    Resetn           = 1'b0;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.vsync_n      = 1'b1;
    bus.stage_finish = '0;
    bus.stage_addr   = '0;
    bus.stage_wdata  = '0;
    bus.stage_we_n   = '1;
    bus.disp_addr    = DISP_A;

    // 1. reset
    step(2);
    chk("rst_disp_en", 32'(bus.disp_enable), 32'd1);
    chk("rst_stage_en", 32'(bus.stage_enable), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_we_n", 32'(bus.sram_we_n), 32'd1);
    chk("rst_addr", 32'(bus.sram_addr), 32'(DISP_A));
    chk("rst_error", 32'(bus.error), 32'd0);
    chk("rst_cur", 32'(bus.cur_stage), 32'd0);
    Resetn = 1'b1;

    // 2. normal run
    exp_q.push_back(3'b001); exp_q.push_back(3'b010); exp_q.push_back(3'b100);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start_disp_off", 32'(bus.disp_enable), 32'd0);
    chk("start_busy", 32'(bus.busy), 32'd1);
    chk("start_no_en", 32'(bus.stage_enable), 32'd0);
    step();
    chk("run0_en", 32'(bus.stage_enable), 32'd1);
    for (int k = 0; k < 5; k++) begin
      bus.stage_we_n = 3'b110;
      bus.stage_addr[0 +: AW] = AW'(k + 16);
      bus.stage_wdata[0 +: DW] = DW'(k);
      step();
    end
    bus.stage_we_n = 3'b111;
    step(99);
    chk("run0_hold99", 32'(bus.stage_enable), 32'd1);
    step();
    chk("run0_done100", 32'(bus.stage_enable), 32'd0);
    chk("start1_cur", 32'(bus.cur_stage), 32'd1);
    step();
    chk("run1_en", 32'(bus.stage_enable), 32'b010);

    // 3. mux table while stage 1 owns the bus, other stages drive junk
    bus.stage_addr[0 +: AW]    = 18'h15555;
    bus.stage_addr[2*AW +: AW] = 18'h0AAAA;
    bus.stage_wdata[0 +: DW]    = 16'h1111;
    bus.stage_wdata[2*DW +: DW] = 16'h2222;
    for (int v = 0; v < 4; v++) begin
      bus.stage_addr[AW +: AW]  = tbl[v].a;
      bus.stage_wdata[DW +: DW] = tbl[v].d;
      bus.stage_we_n = {1'b0, tbl[v].we_n, 1'b0};
      #1;
      chk("mux_addr", 32'(bus.sram_addr), 32'(tbl[v].exp_a));
      chk("mux_wdata", 32'(bus.sram_wdata), 32'(tbl[v].exp_d));
      chk("mux_we_n", 32'(bus.sram_we_n), 32'(tbl[v].exp_we_n));
      step();
    end
    step(15);
    bus.stage_finish = 3'b010;
    bus.stage_addr[AW +: AW] = 18'h1ABCD;
    bus.stage_we_n = 3'b000;
    #1;
    chk("fin1_addr", 32'(bus.sram_addr), 32'h1ABCD);
    chk("fin1_we_n", 32'(bus.sram_we_n), 32'd0);
    step();
    bus.stage_finish = '0;
    chk("start2_we_n", 32'(bus.sram_we_n), 32'd1);
    chk("start2_addr", 32'(bus.sram_addr), 32'(DISP_A));
    chk("start2_en", 32'(bus.stage_enable), 32'd0);
    chk("start2_cur", 32'(bus.cur_stage), 32'd2);
    step();
    bus.stage_we_n = 3'b111;
    chk("run2_en", 32'(bus.stage_enable), 32'b100);
    bus.stage_finish = 3'b011;
    step();
    bus.stage_finish = '0;
    chk("other_fin_ignored", 32'(bus.stage_enable), 32'b100);
    bus.stage_finish = 3'b100;
    step();
    bus.stage_finish = '0;
    chk("wait_disp_en", 32'(bus.disp_enable), 32'd1);
    chk("wait_stage_en", 32'(bus.stage_enable), 32'd0);
    chk("wait_busy", 32'(bus.busy), 32'd1);
    step(3);
    chk("wait_no_done", 32'(bus.done), 32'd0);
    chk("wait_still_busy", 32'(bus.busy), 32'd1);
    bus.vsync_n = 1'b0;
    step();
    bus.vsync_n = 1'b1;
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    step();
    chk("done_cleared", 32'(bus.done), 32'd0);
    chk("done_count1", 32'(done_cnt), 32'd1);

    // 4. watchdog on stage 1
    exp_q.push_back(3'b001); exp_q.push_back(3'b010);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.stage_we_n = 3'b110;
    step();
    bus.stage_we_n = 3'b111;
    step(100);
    chk("wd_start1_cur", 32'(bus.cur_stage), 32'd1);
    step();
    step(49);
    chk("wd_not_yet", 32'(bus.error), 32'd0);
    chk("wd_still_en", 32'(bus.stage_enable), 32'b010);
    step();
    chk("wd_error", 32'(bus.error), 32'd1);
    chk("wd_error_stage", 32'(bus.error_stage), 32'd1);
    chk("wd_disp_en", 32'(bus.disp_enable), 32'd1);
    chk("wd_stage_en", 32'(bus.stage_enable), 32'd0);
    chk("wd_busy", 32'(bus.busy), 32'd0);
    step(3);
    chk("wd_sticky", 32'(bus.error), 32'd1);
    exp_q.push_back(3'b001);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("restart_err_clr", 32'(bus.error), 32'd0);
    chk("restart_cur", 32'(bus.cur_stage), 32'd0);
    chk("restart_disp", 32'(bus.disp_enable), 32'd0);
    step();
    chk("restart_run0", 32'(bus.stage_enable), 32'b001);

    // 5. abort in stage 2 together with its finish
    exp_q.push_back(3'b010); exp_q.push_back(3'b100);
    bus.stage_we_n = 3'b110;
    step();
    bus.stage_we_n = 3'b111;
    step(100);
    step();
    bus.stage_finish = 3'b010;
    step();
    bus.stage_finish = '0;
    step();
    chk("ab_run2", 32'(bus.stage_enable), 32'b100);
    bus.abort = 1'b1;
    bus.stage_finish = 3'b100;
    step();
    bus.stage_finish = '0;
    chk("ab_busy", 32'(bus.busy), 32'd0);
    chk("ab_stage_en", 32'(bus.stage_enable), 32'd0);
    chk("ab_disp_en", 32'(bus.disp_enable), 32'd1);
    chk("ab_no_done", 32'(bus.done), 32'd0);
    bus.start = 1'b1;
    step();
    chk("ab_beats_start", 32'(bus.busy), 32'd0);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    step();
    chk("ab_done_still0", 32'(bus.done), 32'd0);

    // 6. timeout stage with no writes never completes
    exp_q.push_back(3'b001);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step(305);
    chk("nowr_busy", 32'(bus.busy), 32'd1);
    chk("nowr_en", 32'(bus.stage_enable), 32'b001);
    chk("nowr_cur", 32'(bus.cur_stage), 32'd0);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("nowr_abort", 32'(bus.busy), 32'd0);
    step(2);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("done_total", 32'(done_cnt), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_stage_sequencer.md
Name: sram_stage_sequencer

Overview:
Parametrised top-level SRAM ownership sequencer for the decompressor pipeline. It runs NUM_STAGES processing stages in a fixed order (e.g. UART receive, then decode, then colourspace). Each stage gets an exclusive window on the single SRAM controller port. When no stage is running, the display reader owns the port. Replaces hard-coded per-stage top-level FSM/mux logic: it adds per-stage inactivity-timeout completion, a watchdog with error capture, abort/restart, and a status vector.

Parameters:
NUM_STAGES, 3, number of sequenced stages (2..8); stage 0 runs first.
ADDR_W, 18, SRAM address width.
DATA_W, 16, SRAM data width.
TIMEOUT_MASK, 3'b001, bit i=1: stage i completes on write inactivity instead of finish[i].
TIMEOUT_CYCLES, 50_000_000, inactivity cycles that end a timeout-mode stage (1 s at 50 MHz).
WATCHDOG_CYCLES, 2**26-1, max cycles a finish-mode stage may run; 0 disables the watchdog.
CNT_W, 26, width of both counters; must hold TIMEOUT_CYCLES and WATCHDOG_CYCLES.

Ports:
Clock  in  1  system clock (50 MHz)
Resetn  in  1  synchronous active-low reset
start  in  1  level; begin a run (UART start bit seen or pushbutton pressed)
abort  in  1  level; cancel the current run and return to idle
vsync_n  in  1  display vertical sync, active low
stage_finish  in  NUM_STAGES  per-stage done (level or pulse)
stage_addr  in  NUM_STAGES*ADDR_W  packed stage addresses; stage i at [i*ADDR_W +: ADDR_W]
stage_wdata  in  NUM_STAGES*DATA_W  packed stage write data
stage_we_n  in  NUM_STAGES  stage write enables, active low
disp_addr  in  ADDR_W  display reader address
stage_init  out  NUM_STAGES  one-cycle pulse on entry to stage i
stage_enable  out  NUM_STAGES  one-hot level; held high while stage i owns the bus
disp_enable  out  1  display reader enable
sram_addr  out  ADDR_W  to SRAM controller (combinational mux)
sram_wdata  out  DATA_W  to SRAM controller (combinational mux)
sram_we_n  out  1  to SRAM controller (combinational mux)
cur_stage  out  3  index of the active stage
busy  out  1  high in every state except S_IDLE and S_ERROR
done  out  1  one-cycle pulse when a run completes
error  out  1  sticky watchdog error
error_stage  out  3  stage index that tripped the watchdog

Behaviour:
- Reset values: state S_IDLE, stage_init=0, stage_enable=0, disp_enable=1, cur_stage=0, done=0, error=0, error_stage=0, both counters 0.
- Reset is synchronous and active-low, sampled on the rising edge of Clock. The FSM, counters and all registered outputs are registered.
- States: S_IDLE, S_START, S_RUN, S_WAIT_VSYNC, S_ERROR. The enum lives in the package.
- S_IDLE: disp_enable=1. On start=1 and abort=0: cur_stage<=0, disp_enable<=0, go to S_START.
- S_START: stage_init[cur_stage]<=1 for exactly one cycle; clear both counters; go to S_RUN.
- S_RUN: stage_enable[cur_stage]=1.
  - Timer counter: clears on any cycle where stage_we_n[cur_stage]=0; otherwise increments and saturates.
  - activity flag: sets on the first write in the stage; clears in S_START.
- Stage completion:
  - Timeout mode: timer==TIMEOUT_CYCLES-1 AND activity=1. With no write ever, the stage waits indefinitely.
  - Finish mode: stage_finish[cur_stage]=1 sampled in S_RUN. Finish inputs of non-current stages are ignored.
- On completion:
  - stage_enable cleared in the same edge.
  - If cur_stage<NUM_STAGES-1: cur_stage+1, go to S_START. There is exactly one idle cycle between stages, so bus ownership never overlaps.
  - If last stage: disp_enable<=1, go to S_WAIT_VSYNC.
- Watchdog: applies to finish-mode stages only.
  - Counts cycles in S_RUN.
  - At WATCHDOG_CYCLES with no finish: error<=1, error_stage<=cur_stage, stage_enable<=0, disp_enable<=1, go to S_ERROR.
  - If finish and watchdog expiry occur in the same cycle, finish wins.
- S_WAIT_VSYNC: on vsync_n=0, done<=1 for one cycle and go to S_IDLE. If vsync_n is already 0 on entry, exit after one cycle.
- S_ERROR: error held. start=1 clears error, sets cur_stage=0, and goes to S_START.
- abort: in any state other than S_IDLE, go to S_IDLE next edge with all enables 0 and disp_enable=1; no done pulse.
  - abort beats start and completion in the same cycle.
  - abort in S_IDLE is ignored.
  - abort in S_ERROR also clears error.
- Bus mux (combinational):
  - In S_RUN: address, data and we_n come from stage cur_stage.
  - In S_START, S_IDLE, S_WAIT_VSYNC and S_ERROR: sram_addr=disp_addr, sram_we_n=1, sram_wdata=0.
  - we_n is never low outside S_RUN.
- start held high across a run's return to S_IDLE immediately begins a new run on the next cycle.

Decomposition:
- Package sram_seq_pkg:
  - seq_state_t enum.
  - STAGE_IDX_W=3.
  - Default timing constants (TIMEOUT_CYCLES, WATCHDOG_CYCLES at 50 MHz).
- One sub-module, seq_bus_mux: purely combinational; selects a stage's address/data/we_n by index, or falls back to the display reader.
- FSM and counters remain in sram_stage_sequencer.

Test Plan:
1. Reset with Resetn=0 for 2 cycles → disp_enable=1, stage_enable=0, busy=0, sram_we_n=1, sram_addr=disp_addr.
2. Normal run, TIMEOUT_CYCLES=100: start pulse; stage 0 writes 5 words then goes idle.
   - stage_init[0] pulses; stage_enable=3'b001.
   - Stage 0 completes exactly 100 cycles after its last write.
   - stage_finish[1] asserted after 20 cycles → stage 2 entered one cycle later.
   - stage_finish[2] → disp_enable=1.
   - vsync_n low → done pulses once.
3. Mux check: in S_RUN with stage 1 driving addr=18'h1ABCD, we_n=0, and other stages driving junk → sram_addr=18'h1ABCD, sram_we_n=0. One cycle later in S_START → sram_we_n=1.
4. Watchdog, WATCHDOG_CYCLES=50: stage 1 never finishes → error=1, error_stage=1, disp_enable=1 at cycle 50 of S_RUN. Then start → error=0 and stage 0 re-entered.
5. Abort mid stage 2: assert abort together with stage_finish[2] → next state S_IDLE, done=0, stage_enable=0.
6. Timeout stage with no writes → remains in S_RUN beyond 3×TIMEOUT_CYCLES, busy=1.
